amo_mem_responder: RTL and testbench
====================================

AMO_MEM_RESPONDER -- requirements
Module: amo_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL give the number of 32-bit words in the attached RAM (power of two; AW = $clog2(DEPTH_WORDS)).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  the request on req is valid.
REQ-005 req_ready  output  1  the block accepts the request this cycle; a transfer occurs when req_valid and req_ready are both 1.
REQ-006 req  input  data_access_shared_inputs_t  request fields: addr, load, store, be, data_in, id and amo (amo_details_t); is_float, fn3 and subunit_id SHALL be ignored.
REQ-007 resp_valid  output  1  response valid; no backpressure, so the response SHALL be consumed in the cycle it is asserted.
REQ-008 resp_data  output  32  full 32-bit word returned (load data, old AMO value, or SC status).
REQ-009 resp_id  output  id_t  the id of the request being answered.
REQ-010 ram_en  output  1  RAM access strobe.
REQ-011 ram_addr  output  AW  word address, equal to req.addr[AW+1:2]; upper address bits SHALL be ignored, so addresses wrap.
REQ-012 ram_we  output  4  byte write enables.
REQ-013 ram_wdata  output  32  RAM write data.
REQ-014 ram_rdata  input  32  RAM read data, valid exactly one cycle after ram_en with ram_we==0.

Function
REQ-015 FSM states SHALL be IDLE and RMW_WRITE; req_ready SHALL be 1 only in IDLE.
REQ-016 Plain store (store=1, no amo flag): on acceptance, drive ram_en=1, ram_we=be and ram_wdata=data_in in the same cycle; no response is generated; state remains IDLE.
REQ-017 Plain load (load=1, no amo flag): on acceptance, drive ram_en=1, ram_we=0; in the next cycle, resp_valid=1, resp_data=ram_rdata and resp_id=the request id.
REQ-018 Loads SHALL be fully pipelined, sustaining one accepted load per cycle.
REQ-019 Reservation register: a valid bit plus an AW-bit word address.
REQ-020 LR (amo.is_lr): behaves as a plain load and additionally sets the reservation to valid at that word address, replacing any prior reservation.
REQ-021 SC success (amo.is_sc with the reservation valid and its address equal to the request word address): write data_in with ram_we=4'hF; respond next cycle with resp_data=0.
REQ-022 SC failure (amo.is_sc otherwise): perform no write; respond next cycle with resp_data=1.
REQ-023 Any SC SHALL clear the reservation.
REQ-024 RMW accept (amo.is_rmw): in IDLE, issue a read (ram_en=1, ram_we=0), latch data_in, id, op and address, and go to RMW_WRITE.
REQ-025 RMW_WRITE: compute new = f(ram_rdata, data_in) and drive ram_en=1, ram_we=4'hF, ram_wdata=new.
REQ-026 RMW_WRITE: assert resp_valid with resp_data=ram_rdata (the old value), then return to IDLE; be SHALL be ignored for AMOs.
REQ-027 amo.op encodings SHALL be:
- 00001 SWAP: new = rs2
- 00000 ADD: new = rs1 + rs2, modulo 2^32
- 00100 XOR, 01100 AND, 01000 OR: bitwise operation
- 10000 MIN, 10100 MAX: signed compare
- 11000 MINU, 11100 MAXU: unsigned compare
- where rs1 is the old memory value and rs2 is data_in.
REQ-028 An unlisted op under is_rmw SHALL behave as SWAP.
REQ-029 A plain store or an RMW whose word address equals a valid reservation SHALL clear that reservation.
REQ-030 A plain load SHALL NOT affect the reservation.
REQ-031 A response from a prior load, LR or SC MAY coincide with acceptance of the next request; both SHALL proceed without loss.
REQ-032 A request with both load and store set (and no amo flag) SHALL be treated as a store.
REQ-033 A request with neither flag set SHALL be consumed with no RAM access and no response.

Reset
REQ-034 With rst=1 at a clock edge, the next state SHALL be: state=IDLE, reservation invalid, resp_valid=0, ram_en=0, ram_we=0, with req_ready=1 from the first cycle after reset.
REQ-035 Reset asserted in RMW_WRITE or during a pending load response SHALL abort the operation: no write issued and no response issued.

Verification
REQ-036 Store addr 0x10, be=4'b0011, data 0xAABBCCDD over 0x11223344 -> next load at 0x10 returns 0x1122CCDD one cycle after acceptance.
REQ-037 LR at 0x20 (mem 0x5), then SC at 0x20 with data 0x7 -> SC resp_data=0 and memory=0x7; a second SC at 0x20 -> resp_data=1 and memory unchanged.
REQ-038 LR at 0x20, plain store to 0x20, SC at 0x20 -> resp_data=1; LR at 0x20, store to 0x24, SC at 0x20 -> resp_data=0.
REQ-039 AMOMIN with mem=0xFFFFFFFF (-1) and data=0x1 -> resp_data=0xFFFFFFFF, memory stays 0xFFFFFFFF; AMOMINU with the same inputs -> memory becomes 0x1; req_ready=0 for exactly one cycle.
REQ-040 AMOADD with mem=0xFFFFFFFF and data=0x2 -> memory becomes 0x00000001, resp_id equals the request id.
REQ-041 rst asserted in RMW_WRITE -> no ram_we pulse and no resp_valid; a following LR/SC pair on a previously reserved address -> SC returns 1.

Source files
------------

// File: rtl/amo_mem_responder.sv
// Word-addressed data-memory responder with loads, stores, LR/SC and RMW atomics.
// Fronts a single-port synchronous RAM with one-cycle read latency.
package amo_pkg;
  typedef logic [3:0] id_t;

  typedef struct packed {
    logic       is_lr;
    logic       is_sc;
    logic       is_rmw;
    logic [4:0] op;
  } amo_details_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic         load;
    logic         store;
    logic [3:0]   be;
    logic [2:0]   fn3;
    logic [31:0]  data_in;
    id_t          id;
    amo_details_t amo;
    logic         is_float;
    logic [1:0]   subunit_id;
  } data_access_shared_inputs_t;
endpackage

module amo_mem_responder
  import amo_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  data_access_shared_inputs_t req,
  output logic                       resp_valid,
  output logic [31:0]                resp_data,
  output id_t                        resp_id,
  output logic                       ram_en,
  output logic [AW-1:0]              ram_addr,
  output logic [3:0]                 ram_we,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata
);

  typedef enum logic {
    IDLE,
    RMW_WRITE
  } state_t;

  state_t        state;
  logic          res_valid;
  logic [AW-1:0] res_addr;

  logic          pend;
  logic          pend_sc;
  logic          sc_fail;
  id_t           pend_id;

  logic [31:0]   rmw_data;
  logic [4:0]    rmw_op;
  id_t           rmw_id;
  logic [AW-1:0] rmw_addr;

  logic          accept;
  logic [AW-1:0] req_addr;
  logic          plain;
  logic          do_ld;
  logic          do_st;
  logic          do_lr;
  logic          do_sc;
  logic          do_rmw;
  logic          res_hit;
  logic          sc_ok;
  logic [31:0]   amo_new;

  logic          unused_bits;
  assign unused_bits = ^{req.fn3, req.is_float, req.subunit_id,
                         req.addr[31:AW+2], req.addr[1:0]};

  function automatic logic [31:0] amo_calc(
    input logic [4:0]  op,
    input logic [31:0] rs1,
    input logic [31:0] rs2
  );
    logic lt;
    logic ltu;
    lt  = $signed(rs1) < $signed(rs2);
    ltu = rs1 < rs2;
    case (op)
      5'b00000: amo_calc = rs1 + rs2;
      5'b00100: amo_calc = rs1 ^ rs2;
      5'b01100: amo_calc = rs1 & rs2;
      5'b01000: amo_calc = rs1 | rs2;
      5'b10000: amo_calc = lt  ? rs1 : rs2;
      5'b10100: amo_calc = lt  ? rs2 : rs1;
      5'b11000: amo_calc = ltu ? rs1 : rs2;
      5'b11100: amo_calc = ltu ? rs2 : rs1;
      default:  amo_calc = rs2;
    endcase
  endfunction

  assign req_ready = !rst && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_addr  = req.addr[AW+1:2];

  // RMW outranks SC outranks LR; plain ops only when no AMO flag is set
  assign plain  = accept && !(req.amo.is_rmw || req.amo.is_sc || req.amo.is_lr);
  assign do_rmw = accept && req.amo.is_rmw;
  assign do_sc  = accept && req.amo.is_sc && !req.amo.is_rmw;
  assign do_lr  = accept && req.amo.is_lr && !req.amo.is_sc && !req.amo.is_rmw;
  assign do_st  = plain && req.store;
  assign do_ld  = plain && req.load && !req.store;

  assign res_hit = res_valid && (res_addr == req_addr);
  assign sc_ok   = do_sc && res_hit;
  assign amo_new = amo_calc(rmw_op, ram_rdata, rmw_data);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_wdata = req.data_in;
    ram_addr  = req_addr;
    if (state == RMW_WRITE) begin
      ram_addr  = rmw_addr;
      ram_wdata = amo_new;
      if (!rst) begin
        ram_en = 1'b1;
        ram_we = 4'hF;
      end
    end else begin
      unique case (1'b1)
        do_st: begin
          ram_en = 1'b1;
          ram_we = req.be;
        end
        do_ld, do_lr, do_rmw: begin
          ram_en = 1'b1;
        end
        sc_ok: begin
          ram_en = 1'b1;
          ram_we = 4'hF;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = !rst && (pend || state == RMW_WRITE);
  assign resp_id    = (state == RMW_WRITE) ? rmw_id : pend_id;

  always_comb begin
    resp_data = ram_rdata;
    if (state == IDLE && pend_sc) begin
      resp_data = {31'd0, sc_fail};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      pend      <= 1'b0;
      pend_sc   <= 1'b0;
    end else begin
      pend    <= do_ld || do_lr || do_sc;
      pend_sc <= do_sc;
      unique case (state)
        IDLE:      if (do_rmw) state <= RMW_WRITE;
        RMW_WRITE: state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (do_lr) begin
        res_valid <= 1'b1;
        res_addr  <= req_addr;
      end else if (do_sc || ((do_st || do_rmw) && res_hit)) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_id <= req.id;
      sc_fail <= !res_hit;
    end
    if (do_rmw) begin
      rmw_data <= req.data_in;
      rmw_op   <= req.amo.op;
      rmw_id   <= req.id;
      rmw_addr <= req_addr;
    end
  end

endmodule

// File: tb/tb_amo_mem_responder.sv
// Bench for amo_mem_responder: attached RAM plus a transaction-level
// memory/reservation model driven with directed and random requests.
module tb_amo_mem_responder;
  import amo_pkg::*;

  localparam int DW = 64;
  localparam int AW = 6;

  localparam int K_LD   = 0;
  localparam int K_ST   = 1;
  localparam int K_LR   = 2;
  localparam int K_SC   = 3;
  localparam int K_RMW  = 4;
  localparam int K_BOTH = 5;
  localparam int K_NONE = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       req_valid = 1'b0;
  logic                       req_ready;
  data_access_shared_inputs_t req = '0;
  logic                       resp_valid;
  logic [31:0]                resp_data;
  id_t                        resp_id;
  logic                       ram_en;
  logic [AW-1:0]              ram_addr;
  logic [3:0]                 ram_we;
  logic [31:0]                ram_wdata;
  logic [31:0]                ram_rdata;

  amo_mem_responder #(.DEPTH_WORDS(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [31:0] ram [DW];
  int          wr_pulses = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we != 4'h0) wr_pulses <= wr_pulses + 1;
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == 4'h0) ram_rdata <= ram[ram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  logic [31:0]   mdl [DW];
  logic          mrv = 1'b0;
  logic [AW-1:0] mra = '0;

  function automatic logic [31:0] ref_amo(input logic [4:0] op,
                                          input logic [31:0] m,
                                          input logic [31:0] d);
    int      sm;
    int      sd;
    longint  um;
    longint  ud;
    sm = $signed(m);
    sd = $signed(d);
    um = {32'd0, m};
    ud = {32'd0, d};
    case (op)
      5'h00:   return 32'(um + ud);
      5'h04:   return m ^ d;
      5'h0C:   return m & d;
      5'h08:   return m | d;
      5'h10:   return (sm < sd) ? m : d;
      5'h14:   return (sm > sd) ? m : d;
      5'h18:   return (um < ud) ? m : d;
      5'h1C:   return (um > ud) ? m : d;
      default: return d;
    endcase
  endfunction

  function automatic data_access_shared_inputs_t mk(input int k,
      input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
      input id_t id, input logic [4:0] op);
    data_access_shared_inputs_t r;
    r = '0;
    r.addr       = a;
    r.be         = be;
    r.data_in    = d;
    r.id         = id;
    r.amo.op     = op;
    r.fn3        = 3'($urandom);
    r.is_float   = 1'($urandom);
    r.subunit_id = 2'($urandom);
    case (k)
      K_LD:   r.load = 1'b1;
      K_ST:   r.store = 1'b1;
      K_LR:   begin r.load = 1'b1; r.amo.is_lr = 1'b1; end
      K_SC:   begin r.store = 1'b1; r.amo.is_sc = 1'b1; end
      K_RMW:  begin r.load = 1'b1; r.store = 1'b1; r.amo.is_rmw = 1'b1; end
      K_BOTH: begin r.load = 1'b1; r.store = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_apply(input data_access_shared_inputs_t r,
                             output logic eg, output logic [31:0] ed);
    logic [AW-1:0] w;
    w  = r.addr[AW+1:2];
    eg = 1'b0;
    ed = '0;
    if (r.amo.is_rmw) begin
      eg = 1'b1;
      ed = mdl[w];
      mdl[w] = ref_amo(r.amo.op, mdl[w], r.data_in);
      if (mrv && mra == w) mrv = 1'b0;
    end else if (r.amo.is_sc) begin
      eg = 1'b1;
      if (mrv && mra == w) begin
        mdl[w] = r.data_in;
        ed = 32'd0;
      end else begin
        ed = 32'd1;
      end
      mrv = 1'b0;
    end else if (r.amo.is_lr) begin
      eg  = 1'b1;
      ed  = mdl[w];
      mrv = 1'b1;
      mra = w;
    end else if (r.store) begin
      for (int b = 0; b < 4; b++)
        if (r.be[b]) mdl[w][8*b +: 8] = r.data_in[8*b +: 8];
      if (mrv && mra == w) mrv = 1'b0;
    end else if (r.load) begin
      eg = 1'b1;
      ed = mdl[w];
    end
  endtask

  task automatic send(input data_access_shared_inputs_t r,
                      output logic got, output logic [31:0] d,
                      output id_t id, output int lat, output int busy);
    int n;
    n = 0;
    req = r;
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout ready=%0b required=1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req = '0;
    got = 1'b0;
    d = '0;
    id = '0;
    lat = -1;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!req_ready) busy++;
      if (resp_valid && !got) begin
        got = 1'b1;
        d = resp_data;
        id = resp_id;
        lat = i;
      end
    end
  endtask

  task automatic run(input data_access_shared_inputs_t r,
                     output logic eg, output logic [31:0] ed,
                     output logic got, output logic [31:0] d,
                     output id_t id, output int lat, output int busy);
    model_apply(r, eg, ed);
    send(r, got, d, id, lat, busy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_resp_valid got=%0b want=0", resp_valid);
    end
    total++;
    if (ram_en !== 1'b0) begin
      bad++; $display("FAIL rst_ram_en got=%0b want=0", ram_en);
    end
    total++;
    if (ram_we !== 4'h0) begin
      bad++; $display("FAIL rst_ram_we got=%h want=0", ram_we);
    end
    rst = 1'b0;
    mrv = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_req_ready got=%0b want=1", req_ready);
    end
  endtask

  task automatic init_mem();
    logic eg, got;
    logic [31:0] ed, d;
    id_t id;
    int lat, busy;
    for (int w = 0; w < DW; w++)
      run(mk(K_ST, 32'(w << 2), 4'hF, $urandom, 4'h0, 5'h0),
          eg, ed, got, d, id, lat, busy);
  endtask

  task automatic test_store_load();
    logic eg, got;
    logic [31:0] ed, d;
    id_t id;
    int lat, busy, p0;
    run(mk(K_ST, 32'h10, 4'hF, 32'h11223344, 4'h1, 5'h0),
        eg, ed, got, d, id, lat, busy);
    run(mk(K_ST, 32'h10, 4'b0011, 32'hAABBCCDD, 4'h2, 5'h0),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (got !== 1'b0) begin
      bad++; $display("FAIL st_no_resp got=%0b want=0", got);
    end
    run(mk(K_LD, 32'h10, 4'h0, 32'h0, 4'h5, 5'h0),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h1122CCDD) begin
      bad++; $display("FAIL ld_merge got=%h want=%h", d, 32'h1122CCDD);
    end
    total++;
    if (lat !== 0) begin
      bad++; $display("FAIL ld_latency got=%0d want=0", lat);
    end
    total++;
    if (id !== 4'h5) begin
      bad++; $display("FAIL ld_id got=%h want=5", id);
    end
    run(mk(K_BOTH, 32'h14, 4'hF, 32'hCAFE0001, 4'h3, 5'h0),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (got !== 1'b0 || ram[5] !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL ldst_as_store resp=%0b mem=%h want resp=0 mem=%h",
               got, ram[5], 32'hCAFE0001);
    end
    p0 = wr_pulses;
    run(mk(K_NONE, 32'h18, 4'hF, 32'h0BADF00D, 4'h4, 5'h0),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (got !== 1'b0 || wr_pulses !== p0 || ram[6] !== mdl[6]) begin
      bad++;
      $display("FAIL noop resp=%0b writes=%0d mem=%h want 0 %0d %h",
               got, wr_pulses - p0, ram[6], 0, mdl[6]);
    end
  endtask

  task automatic test_lr_sc();
    logic eg, got;
    logic [31:0] ed, d;
    id_t id;
    int lat, busy;
    run(mk(K_ST, 32'h20, 4'hF, 32'h5, 4'h0, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_LR, 32'h20, 4'h0, 32'h0, 4'h6, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h5 || lat !== 0) begin
      bad++; $display("FAIL lr_data got=%h lat=%0d want=5 lat=0", d, lat);
    end
    run(mk(K_SC, 32'h20, 4'h0, 32'h7, 4'h7, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h0 || ram[8] !== 32'h7 || id !== 4'h7) begin
      bad++;
      $display("FAIL sc_ok resp=%h mem=%h id=%h want 0 7 7", d, ram[8], id);
    end
    run(mk(K_SC, 32'h20, 4'h0, 32'h9, 4'h8, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h1 || ram[8] !== 32'h7) begin
      bad++; $display("FAIL sc_again resp=%h mem=%h want 1 7", d, ram[8]);
    end
  endtask

  task automatic test_reservation();
    logic eg, got;
    logic [31:0] ed, d;
    id_t id;
    int lat, busy;
    run(mk(K_LR, 32'h20, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_ST, 32'h20, 4'h1, 32'h33, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_SC, 32'h20, 4'h0, 32'h44, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h1 || ram[8] !== mdl[8]) begin
      bad++; $display("FAIL sc_after_st resp=%h want=1", d);
    end
    run(mk(K_LR, 32'h20, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_ST, 32'h24, 4'hF, 32'h55, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_SC, 32'h20, 4'h0, 32'h66, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h0 || ram[8] !== 32'h66) begin
      bad++; $display("FAIL sc_other_st resp=%h mem=%h want 0 66", d, ram[8]);
    end
    run(mk(K_LR, 32'h28, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_LD, 32'h28, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_SC, 32'h28, 4'h0, 32'h77, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL sc_after_ld resp=%h want=0", d);
    end
    run(mk(K_LR, 32'h2C, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    run(mk(K_SC, 32'h2C + DW * 4, 4'h0, 32'h88, 4'h1, 5'h0),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h0 || ram[11] !== 32'h88) begin
      bad++; $display("FAIL sc_wrap resp=%h mem=%h want 0 88", d, ram[11]);
    end
  endtask

  task automatic test_amo();
    logic eg, got;
    logic [31:0] ed, d, dat;
    logic [4:0] ops [9];
    id_t id;
    int lat, busy;
    ops = '{5'h01, 5'h00, 5'h04, 5'h0C, 5'h08, 5'h10, 5'h14, 5'h18, 5'h1C};
    run(mk(K_ST, 32'h30, 4'hF, 32'hFFFFFFFF, 4'h0, 5'h0),
        eg, ed, got, d, id, lat, busy);
    run(mk(K_RMW, 32'h30, 4'h0, 32'h1, 4'h2, 5'h10),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'hFFFFFFFF || ram[12] !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL amomin resp=%h mem=%h want ffffffff ffffffff",
                      d, ram[12]);
    end
    total++;
    if (busy !== 1) begin
      bad++; $display("FAIL rmw_busy got=%0d want=1", busy);
    end
    run(mk(K_RMW, 32'h30, 4'h0, 32'h1, 4'h3, 5'h18),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'hFFFFFFFF || ram[12] !== 32'h1) begin
      bad++; $display("FAIL amominu resp=%h mem=%h want ffffffff 1", d, ram[12]);
    end
    run(mk(K_ST, 32'h30, 4'hF, 32'hFFFFFFFF, 4'h0, 5'h0),
        eg, ed, got, d, id, lat, busy);
    run(mk(K_RMW, 32'h30, 4'h3, 32'h2, 4'hA, 5'h00),
        eg, ed, got, d, id, lat, busy);
    total++;
    if (ram[12] !== 32'h1 || id !== 4'hA || d !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL amoadd mem=%h id=%h resp=%h want 1 a ffffffff",
                      ram[12], id, d);
    end
    for (int i = 0; i < 27; i++) begin
      dat = (i % 3 == 0) ? 32'h80000000 ^ $urandom : $urandom;
      run(mk(K_RMW, 32'h34, 4'($urandom), dat, 4'(i), ops[i % 9]),
          eg, ed, got, d, id, lat, busy);
      total++;
      if (got !== 1'b1 || d !== ed || ram[13] !== mdl[13] || lat !== 0) begin
        bad++;
        $display("FAIL amo_op%h resp=%h mem=%h want resp=%h mem=%h",
                 ops[i % 9], d, ram[13], ed, mdl[13]);
      end
    end
  endtask

  task automatic test_random();
    data_access_shared_inputs_t r;
    logic eg, got;
    logic [31:0] ed, d, a;
    id_t id;
    int lat, busy, w;
    for (int i = 0; i < 200; i++) begin
      w = $urandom_range(0, 3);
      a = ($urandom & ~32'(AW'('1) << 2)) | 32'(w << 2);
      r = mk($urandom_range(0, 6), a, 4'($urandom), $urandom, 4'($urandom),
             5'($urandom));
      run(r, eg, ed, got, d, id, lat, busy);
      total++;
      if (got !== eg || (eg && (d !== ed || id !== r.id || lat !== 0))) begin
        bad++;
        $display("FAIL rand_resp v=%0b d=%h id=%h want v=%0b d=%h id=%h",
                 got, d, id, eg, ed, r.id);
      end
      total++;
      if (ram[w] !== mdl[w]) begin
        bad++; $display("FAIL rand_mem got=%h want=%h", ram[w], mdl[w]);
      end
    end
  endtask

  task automatic test_back_to_back();
    data_access_shared_inputs_t r;
    logic eg;
    logic [31:0] ed;
    int k;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : K_LD;
      r = mk(k, 32'($urandom_range(0, 3) << 2), 4'($urandom), $urandom,
             4'($urandom), 5'h0);
      model_apply(r, eg, ed);
      req = r;
      req_valid = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready got=%0b want=1", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (resp_valid !== eg ||
          (eg && (resp_data !== ed || resp_id !== r.id))) begin
        bad++;
        $display("FAIL b2b_resp v=%0b d=%h id=%h want v=%0b d=%h id=%h",
                 resp_valid, resp_data, resp_id, eg, ed, r.id);
      end
    end
    req_valid = 1'b0;
    req = '0;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      total++;
      if (ram[w] !== mdl[w]) begin
        bad++; $display("FAIL b2b_mem w=%0d got=%h want=%h", w, ram[w], mdl[w]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic eg, got;
    logic [31:0] ed, d;
    id_t id;
    int lat, busy, p0;
    run(mk(K_LR, 32'h40, 4'h0, 0, 4'h1, 5'h0), eg, ed, got, d, id, lat, busy);
    req = mk(K_RMW, 32'h44, 4'h0, 32'h12345678, 4'h2, 5'h01);
    req_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req = '0;
    rst = 1'b1;
    p0 = wr_pulses;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || ram_we !== 4'h0) begin
      bad++; $display("FAIL abort_rmw resp=%0b we=%h want 0 0", resp_valid, ram_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mrv = 1'b0;
    @(negedge clk);
    total++;
    if (wr_pulses !== p0 || ram[17] !== mdl[17] || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_nowrite writes=%0d mem=%h want 0 %h",
               wr_pulses - p0, ram[17], mdl[17]);
    end
    req = mk(K_LD, 32'h44, 4'h0, 0, 4'h3, 5'h0);
    req_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL abort_ld resp=%0b want=0", resp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(mk(K_SC, 32'h40, 4'h0, 32'h99, 4'h4, 5'h0), eg, ed, got, d, id, lat, busy);
    total++;
    if (d !== 32'h1 || ram[16] !== mdl[16]) begin
      bad++; $display("FAIL sc_after_rst resp=%h mem=%h want 1 %h",
                      d, ram[16], mdl[16]);
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_lr_sc();
    test_reservation();
    test_amo();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
